// File: rtl/rf_write_ctrl.sv
// Write-port controller for a 32 x 32 register file: arbitrates two requesters (ALU, load) and sweep-clears after reset.
// Latency 1 (registered WR_LOAD/WR_DATA); one write per cycle, readiness combinational from VALIDs, low during INIT.
module rf_write_ctrl #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid_i,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [4:0]  b_addr_i,
    input  logic [31:0] b_data_i,
    output logic        b_ready_o,
    output logic [31:0] wr_load_o,
    output logic [31:0] wr_data_o,
    output logic        init_done_o
);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;          // 0 = A has priority, 1 = B
    logic [31:0] wr_load_q, wr_load_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        init_done_q, init_done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        wr_load_d   = '0;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;
        a_ready_o   = 1'b0;
        b_ready_o   = 1'b0;

        if (state_q == S_INIT) begin
            if (CLEAR_ON_RESET) begin
                wr_load_d = 32'd1 << cnt_q;
                wr_data_d = '0;
                if (cnt_q == 5'd31) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end else begin
                state_d     = S_RUN;
                init_done_d = 1'b1;
            end
        end else begin
            a_ready_o = a_valid_i & (~b_valid_i | ~ptr_q);
            b_ready_o = b_valid_i & (~a_valid_i | ptr_q);
            // r0 is hard-wired zero: accept the write but never load it
            if (a_ready_o) begin
                wr_load_d = (a_addr_i == 5'd0) ? 32'd0 : (32'd1 << a_addr_i);
                wr_data_d = a_data_i;
            end else if (b_ready_o) begin
                wr_load_d = (b_addr_i == 5'd0) ? 32'd0 : (32'd1 << b_addr_i);
                wr_data_d = b_data_i;
            end
            if (a_valid_i && b_valid_i) begin
                ptr_d = a_ready_o;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            wr_load_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            wr_load_q   <= wr_load_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign wr_load_o   = wr_load_q;
    assign wr_data_o   = wr_data_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl: sweep, arbitration, r0, mid-operation reset, and the no-sweep variant.
module tb_rf_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rst1_n;
    logic        a_vld, b_vld, a_rdy, b_rdy;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data, wr_load, wr_data;
    logic        init_done;

    logic        a1_vld, a1_rdy, b1_rdy, init1_done;
    logic [4:0]  a1_addr;
    logic [31:0] a1_data, wr1_load, wr1_data;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] load;
        logic [31:0] data;
    } wr_t;
    wr_t         exp_q[$];
    logic [31:0] last_data;

    always #5 clk = ~clk;

    rf_write_ctrl #(.CLEAR_ON_RESET(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_vld), .a_addr_i(a_addr), .a_data_i(a_data), .a_ready_o(a_rdy),
        .b_valid_i(b_vld), .b_addr_i(b_addr), .b_data_i(b_data), .b_ready_o(b_rdy),
        .wr_load_o(wr_load), .wr_data_o(wr_data), .init_done_o(init_done)
    );

    rf_write_ctrl #(.CLEAR_ON_RESET(1'b0)) u1 (
        .clk(clk), .rst_n(rst1_n),
        .a_valid_i(a1_vld), .a_addr_i(a1_addr), .a_data_i(a1_data), .a_ready_o(a1_rdy),
        .b_valid_i(1'b0), .b_addr_i(5'd0), .b_data_i(32'd0), .b_ready_o(b1_rdy),
        .wr_load_o(wr1_load), .wr_data_o(wr1_data), .init_done_o(init1_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] onehot(input logic [4:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a != 5'd0) r[a] = 1'b1;
        return r;
    endfunction

    // Drive one RUN cycle, check grants, then check the registered write one edge later.
    task automatic run_cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                             input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                             input logic era, input logic erb, input string tag);
        wr_t e, g;
        a_vld = av; a_addr = aa; a_data = ad;
        b_vld = bv; b_addr = ba; b_data = bd;
        #1;
        chk({tag, "_a_rdy"}, {31'd0, a_rdy}, {31'd0, era});
        chk({tag, "_b_rdy"}, {31'd0, b_rdy}, {31'd0, erb});
        if (era)      begin e.load = onehot(aa); e.data = ad; end
        else if (erb) begin e.load = onehot(ba); e.data = bd; end
        else          begin e.load = 32'd0;      e.data = last_data; end
        last_data = e.data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        g = exp_q.pop_front();
        chk({tag, "_load"}, wr_load, g.load);
        chk({tag, "_data"}, wr_data, g.data);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0;
        a_vld = 1'b1; a_addr = 5'd3; a_data = 32'h1234_5678;
        b_vld = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        a1_vld = 1'b0; a1_addr = 5'd0; a1_data = 32'd0;
        last_data = 32'd0;
        #3;
        chk("rst_load", wr_load, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        chk("rst_a_rdy", {31'd0, a_rdy}, 32'd0);
        chk("rst1_done", {31'd0, init1_done}, 32'd0);
        #19;
        rst_n = 1'b1; rst1_n = 1'b1;

        // Sweep with A requesting throughout INIT
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep%0d_load", i), wr_load, 32'd1 << i);
            chk($sformatf("sweep%0d_data", i), wr_data, 32'd0);
            chk($sformatf("sweep%0d_done", i), {31'd0, init_done}, {31'd0, (i == 31)});
            chk($sformatf("nosweep%0d_load", i), wr1_load, 32'd0);
            chk($sformatf("nosweep%0d_done", i), {31'd0, init1_done}, 32'd1);
            if (i < 31) chk($sformatf("sweep%0d_a_rdy", i), {31'd0, a_rdy}, 32'd0);
            if (i == 30) a_vld = 1'b0;
        end

        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, "idle0");
        run_cycle(1, 5, 32'hAAAA_AAAA, 0, 0, 0, 1, 0, "a_only");
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, "after_a");
        run_cycle(1, 1, 32'h0000_1111, 1, 2, 32'h0000_2222, 1, 0, "both1");
        run_cycle(1, 1, 32'h0000_3333, 1, 2, 32'h0000_4444, 0, 1, "both2");
        run_cycle(1, 1, 32'h0000_5555, 1, 2, 32'h0000_6666, 1, 0, "both3");
        run_cycle(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 1, "b_only");
        run_cycle(1, 9, 32'h0000_0009, 1, 31, 32'hFFFF_0000, 0, 1, "both_ptr_b");
        run_cycle(1, 0, 32'h5555_5555, 0, 0, 0, 1, 0, "r0");
        run_cycle(1, 3, 32'hCAFE_0003, 0, 0, 0, 1, 0, "pre_rst");
        a_vld = 1'b0;

        // Reset mid-operation while 0x8 is registered
        rst_n = 1'b0;
        #1;
        chk("midrst_load", wr_load, 32'd0);
        chk("midrst_done", {31'd0, init_done}, 32'd0);
        chk("midrst_data", wr_data, 32'd0);
        #2;
        rst_n = 1'b1;
        last_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("resweep%0d_load", i), wr_load, 32'd1 << i);
            chk($sformatf("resweep%0d_done", i), {31'd0, init_done}, 32'd0);
        end

        // No-sweep instance: first transfer
        chk("nosweep_idle_load", wr1_load, 32'd0);
        a1_vld = 1'b1; a1_addr = 5'd4; a1_data = 32'h0BAD_F00D;
        #1;
        chk("nosweep_a_rdy", {31'd0, a1_rdy}, 32'd1);
        @(posedge clk); #1;
        a1_vld = 1'b0;
        chk("nosweep_xfer_load", wr1_load, 32'h0000_0010);
        chk("nosweep_xfer_data", wr1_data, 32'h0BAD_F00D);
        @(posedge clk); #1;
        chk("nosweep_after_load", wr1_load, 32'd0);
        chk("nosweep_after_data", wr1_data, 32'h0BAD_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1: 1 = sweep-clear all 32 registers after reset; 0 = skip the sweep.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be cleared when RESET is low, independent of CLK.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RESET  in  1  asynchronous active-low reset.
REQ-005 A_VALID  in  1  requester A (ALU writeback) write request.
REQ-006 A_ADDR  in  5  requester A destination register.
REQ-007 A_DATA  in  32  requester A write data.
REQ-008 A_READY  out  1  requester A grant; transfer occurs when A_VALID and A_READY are both high at a rising edge.
REQ-009 B_VALID / B_ADDR / B_DATA / B_READY  in/in/in/out  1/5/32/1  requester B (memory load) port, same meaning as A.
REQ-010 WR_LOAD  out  32  one-hot LOAD enables to the 32 REG32 registers (bit n = register n).
REQ-011 WR_DATA  out  32  shared D bus to the register array.
REQ-012 INIT_DONE  out  1  high once the controller is in RUN.

Function
REQ-013 Two states, INIT and RUN; reset SHALL enter INIT with sweep counter 0 and priority pointer = A.
REQ-014 INIT with CLEAR_ON_RESET=1: each cycle SHALL drive WR_LOAD = one-hot(counter), WR_DATA = 0, counter +1; after the cycle with counter 31, SHALL enter RUN (exactly 32 sweep cycles, counter does not wrap).
REQ-015 INIT with CLEAR_ON_RESET=0: SHALL enter RUN on the first rising edge after reset release, WR_LOAD never asserted.
REQ-016 A_READY and B_READY SHALL be 0 throughout INIT.
REQ-017 RUN grant, combinational from VALIDs and pointer: only A valid -> A_READY=1; only B valid -> B_READY=1; both valid -> requester named by pointer; never both READY high.
REQ-018 Pointer SHALL toggle to the loser only after a contested (both-valid) transfer; uncontested transfers leave it unchanged.
REQ-019 On a transfer, the next cycle SHALL show WR_LOAD = one-hot(granted ADDR) and WR_DATA = granted DATA for exactly one cycle (latency 1, registered outputs).
REQ-020 Transfer to address 0 SHALL be accepted (READY high) but SHALL produce WR_LOAD = 0 (r0 hard-zero); WR_DATA still updates.
REQ-021 Cycles without a transfer SHALL drive WR_LOAD = 0; WR_DATA SHALL hold its last value.
REQ-022 Throughput: one write per cycle; back-to-back transfers SHALL produce WR_LOAD pulses on consecutive cycles.
REQ-023 Requesters hold VALID, ADDR, DATA stable until granted; the controller SHALL NOT buffer more than the single registered write.
REQ-024 INIT_DONE SHALL be registered, rising in the first RUN cycle and staying high until reset.

Reset
REQ-025 While RESET low: WR_LOAD = 0, WR_DATA = 0, A_READY = B_READY = 0, INIT_DONE = 0, counter 0, pointer A.
REQ-026 Reset asserted mid-operation SHALL discard any registered write in the same instant (WR_LOAD forced 0 asynchronously) and restart INIT after release.

Verification
REQ-027 Reset release, CLEAR_ON_RESET=1 -> WR_LOAD = 0x00000001, 0x00000002 ... 0x80000000 over 32 cycles with WR_DATA=0, then INIT_DONE=1; A_VALID held high during sweep -> A_READY stays 0.
REQ-028 RUN, A only: ADDR=5, DATA=0xAAAAAAAA -> A_READY=1, next cycle WR_LOAD=0x00000020, WR_DATA=0xAAAAAAAA, following cycle WR_LOAD=0.
REQ-029 Both valid 3 cycles (A:ADDR=1, B:ADDR=2, new data each cycle) -> grants A, B, A; WR_LOAD 0x2, 0x4, 0x2.
REQ-030 A_VALID with ADDR=0, DATA=0x55555555 -> A_READY=1, WR_LOAD=0, WR_DATA=0x55555555 next cycle.
REQ-031 Assert RESET between transfer edge and next edge (WR_LOAD=0x00000008) -> WR_LOAD drops to 0 immediately, INIT_DONE=0, sweep restarts at bit 0 after release.
REQ-032 CLEAR_ON_RESET=0 -> INIT_DONE=1 one cycle after reset release, no WR_LOAD pulse before first transfer.
